// File: rtl/reg_dump_reader_if.sv
// Output word stream of the register-dump reader: one tagged word per
// valid/ready handshake.
interface reg_dump_reader_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Sequential reader for the register bank. It scans a wrapping address range
// through one asynchronous read port, streams each word tagged with its
// address, and keeps an XOR checksum of the accepted words.
//
// state | meaning
// IDLE  | waiting for start; abort ignored
// FETCH | first read of the range, captures word at ptr
// SEND  | word held on the stream; each handshake captures the next word
// DONE  | one-cycle done pulse, then back to IDLE
module reg_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  reg_dump_reader_if.master out_if,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] last_q;
  logic          valid_q;
  logic          last_flag_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] cks_q;
  logic [AW-1:0] ptr_inc;
  logic          handshake;

  // Pointer advance wraps modulo the bank size.
  assign ptr_inc   = AW'((32'(ptr) + 32'd1) % NREGS);
  assign handshake = valid_q && out_if.out_ready;

  // Read port always follows the fetch pointer so its value is deterministic in every state.
  assign rd_addr          = ptr;
  assign out_if.out_valid = valid_q;
  assign out_if.out_addr  = addr_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_last  = last_flag_q;
  assign busy             = (state == FETCH) || (state == SEND);
  assign done             = (state == DONE);
  assign checksum         = cks_q;

  // Dump sequencer: range latch, word capture, handshake and checksum accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      last_q      <= '0;
      valid_q     <= 1'b0;
      last_flag_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cks_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_q <= last_addr;
            ptr    <= first_addr;
            cks_q  <= '0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            valid_q     <= 1'b0;
            last_flag_q <= 1'b0;
            state       <= IDLE;
          end else begin
            data_q      <= rd_data;
            addr_q      <= ptr;
            last_flag_q <= (ptr == last_q);
            valid_q     <= 1'b1;
            ptr         <= ptr_inc;
            state       <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a handshake in the same cycle: the word is not counted.
          if (abort) begin
            valid_q     <= 1'b0;
            last_flag_q <= 1'b0;
            state       <= IDLE;
          end else if (handshake) begin
            cks_q <= cks_q ^ data_q;
            if (last_flag_q) begin
              valid_q <= 1'b0;
              state   <= DONE;
            end else begin
              data_q      <= rd_data;
              addr_q      <= ptr;
              last_flag_q <= (ptr == last_q);
              ptr         <= ptr_inc;
            end
          end
        end
        DONE: begin
          if (abort) begin
            valid_q     <= 1'b0;
            last_flag_q <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: an address-list reference model,
// a per-cycle compare process and a per-dump scoreboard.
module tb_reg_dump_reader;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [DW-1:0] bank [NREGS];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  reg_dump_reader_if #(.AW(AW), .DW(DW)) sif ();

  reg_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_if     (sif),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  assign rd_data = bank[rd_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is the list of addresses still to present;
  // phase 0 idle, 1 first read, 2 streaming, 3 done pulse.
  int            m_phase = 0;
  int            m_q[$];
  logic [AW-1:0] m_ptr = '0;
  logic          exp_valid = 1'b0;
  logic          exp_last = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] exp_cks = '0;

  task automatic present_next();
    int a;
    a = m_q.pop_front();
    exp_addr  = AW'(a);
    exp_data  = bank[a];
    exp_last  = (m_q.size() == 0);
    exp_valid = 1'b1;
    m_ptr     = AW'((a + 1) % NREGS);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_q = {}; m_ptr = '0;
      exp_valid = 0; exp_last = 0; exp_addr = '0; exp_data = '0; exp_cks = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          int n;
          n = ((int'(last_addr) - int'(first_addr) + NREGS) % NREGS) + 1;
          m_q = {};
          for (int i = 0; i < n; i++) m_q.push_back((int'(first_addr) + i) % NREGS);
          m_ptr = first_addr;
          exp_cks = '0;
          m_phase = 1;
        end
        1: if (abort) begin
          exp_valid = 0; exp_last = 0; m_phase = 0;
        end else begin
          present_next();
          m_phase = 2;
        end
        2: if (abort) begin
          exp_valid = 0; exp_last = 0; m_phase = 0;
        end else if (exp_valid && sif.out_ready) begin
          exp_cks ^= exp_data;
          if (exp_last) begin
            exp_valid = 0;
            m_phase = 3;
          end else present_next();
        end
        default: begin
          if (abort) begin exp_valid = 0; exp_last = 0; end
          m_phase = 0;
        end
      endcase
    end
  end

  // Scoreboard of accepted words, collected where a handshake is about to happen.
  int            sb_addr[$];
  logic [DW-1:0] sb_data[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", sif.out_valid, exp_valid);
      if (exp_valid) begin
        check("addr", sif.out_addr, exp_addr);
        check("data", sif.out_data, exp_data);
        check("last", sif.out_last, exp_last);
      end
      check("rd_addr", rd_addr, m_ptr);
      check("busy", busy, (m_phase == 1 || m_phase == 2));
      check("done", done, (m_phase == 3));
      check("checksum", checksum, exp_cks);
      if (!reset && !abort && sif.out_valid && sif.out_ready) begin
        sb_addr.push_back(int'(sif.out_addr));
        sb_data.push_back(sif.out_data);
      end
    end
  end

  // ready_mode: 0 always ready, 1 random 50%, 2 stalled for the first cycles.
  task automatic run_dump(input int f, input int l, input int ready_mode, output int cyc);
    int n;
    logic [DW-1:0] snap[$];
    logic [DW-1:0] xv;
    logic [DW-1:0] saved;
    n = ((l - f + NREGS) % NREGS) + 1;
    snap = {};
    xv = '0;
    for (int i = 0; i < n; i++) begin
      snap.push_back(bank[(f + i) % NREGS]);
      xv ^= bank[(f + i) % NREGS];
    end
    saved = bank[f];
    sb_addr = {}; sb_data = {};
    first_addr = AW'(f); last_addr = AW'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      case (ready_mode)
        0: sif.out_ready = 1'b1;
        1: sif.out_ready = 1'($urandom_range(0, 1));
        default: sif.out_ready = (cyc >= 6);
      endcase
      if (ready_mode == 2 && cyc == 3) bank[f] = ~saved;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    bank[f] = saved;
    sif.out_ready = 1'b0;
    check("hs_count", sb_addr.size(), n);
    for (int i = 0; i < n && i < sb_addr.size(); i++) begin
      check("sb_addr", sb_addr[i], (f + i) % NREGS);
      check("sb_data", sb_data[i], snap[i]);
    end
    check("sb_checksum", checksum, xv);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals();
    check("rst_valid", sif.out_valid, 0);
    check("rst_last", sif.out_last, 0);
    check("rst_addr", sif.out_addr, 0);
    check("rst_data", sif.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_rd_addr", rd_addr, 0);
  endtask

  initial begin
    int cyc;
    sif.out_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) bank[i] = DW'(i) * 32'h0101_0101;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    check_reset_vals();

    // Full range, always ready: 32 words, DONE entry 33 cycles after FETCH entry.
    run_dump(0, 31, 0, cyc);
    check("full_cycles", cyc, 33);
    check("full_checksum", checksum, 32'h0000_0000);

    // Wrapping range 30..1.
    run_dump(30, 1, 0, cyc);
    check("wrap_checksum", checksum, 32'h0000_0000);

    // Single word with a stalled consumer and a bank write to the captured register.
    run_dump(7, 7, 2, cyc);
    check("single_checksum", checksum, 32'h0707_0707);
    check("single_model_cks", exp_cks, 32'h0707_0707);

    // Random ready over 3..12.
    run_dump(3, 12, 1, cyc);
    check("rand_checksum", checksum, 32'h0F0F_0F0F);

    // Abort in the 4th SEND cycle of a full dump.
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sif.out_ready = 1'b0;
    check("abort_valid", sif.out_valid, 0);
    check("abort_busy", busy, 0);
    repeat (3) begin @(posedge clk); #1; check("abort_no_done", done, 0); end
    run_dump(5, 5, 0, cyc);
    check("after_abort_cks", checksum, 32'h0505_0505);

    // Start while busy is ignored, then reset mid-dump.
    first_addr = 5'd2; last_addr = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sif.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    first_addr = 5'd25; last_addr = 5'd26; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    sif.out_ready = 1'b0;
    check_reset_vals();

    // Randomized ranges, ready patterns and bank contents.
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 4; k++) bank[$urandom_range(0, NREGS - 1)] = $urandom;
      run_dump(int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
               int'($urandom_range(0, 1)), cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
